rr_arb_mux: RTL and testbench

Parametrised N-channel round-robin arbiter and multiplexer with valid/ready handshakes on every port and a one-beat registered output stage. It merges N independent producer streams of Nbits-wide data into one consumer stream with fair, starvation-free scheduling and full throughput of one beat per cycle. It is the successor to the fixed-priority arbiter and sequencer helpers. It sits wherever several requesters share one downstream port, for example bus masters into a memory port or units into a writeback path.

---
 rtl/rr_arb_mux.sv | 149 ++++++++++++++
 tb/tb_rr_arb_mux.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin arbiter and multiplexer with valid/ready
// handshakes and a single registered output beat.
// Optional packet lock: define RR_ARB_MUX_LOCK_EN to keep a channel's grant
// from its first beat through the beat carrying in_last=1.
module rr_arb_mux #(
    parameter int N     = 2,
    parameter int Nbits = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*Nbits-1:0] in_data,
    input  logic [N-1:0]       in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Nbits-1:0]   out_data,
    output logic               out_last,
    output logic [N-1:0]       out_grant
);

    // Pointer width; a single channel still gets one (constant-zero) bit.
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic             out_valid_q, out_valid_d;
    logic [Nbits-1:0] out_data_q,  out_data_d;
    logic             out_last_q,  out_last_d;
    logic [N-1:0]     out_grant_q, out_grant_d;
    logic [PW-1:0]    ptr_q,       ptr_d;

    logic             load;
    logic             take;
    logic             win_found;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    cand_idx;
    int               cand;
    logic [Nbits-1:0] chan_data [N];

`ifdef RR_ARB_MUX_LOCK_EN
    logic             lock_q,    lock_d;
    logic [PW-1:0]    lock_ch_q, lock_ch_d;
`endif

    // Slice the flat input data bus into one word per channel.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*Nbits +: Nbits];
            assign in_ready[gi]  = take && (win_idx == PW'(gi));
        end
    endgenerate

    // The output slot can accept a new beat when empty or draining this cycle.
    assign load = !out_valid_q || out_ready;
    assign take = load && win_found;

    // Find the first valid channel starting at ptr and wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = PW'(cand);
            if (!win_found && in_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
`ifdef RR_ARB_MUX_LOCK_EN
        // A locked packet owns the port even while its channel is idle.
        if (lock_q) begin
            win_found = in_valid[lock_ch_q];
            win_idx   = lock_ch_q;
        end
`endif
    end

    // Next state of the output beat register and the priority pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_grant_d = out_grant_q;
        ptr_d       = ptr_q;
`ifdef RR_ARB_MUX_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = chan_data[win_idx];
            out_last_d  = in_last[win_idx];
            out_grant_d = in_ready;
            if (N == 1) begin
                ptr_d = '0;
            end else if (win_idx == PW'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + 1'b1;
            end
`ifdef RR_ARB_MUX_LOCK_EN
            if (!in_last[win_idx]) begin
                lock_d    = 1'b1;
                lock_ch_d = win_idx;
            end else begin
                lock_d    = 1'b0;
            end
`endif
        end else if (out_ready) begin
            // Beat drained with nothing replacing it; payload is left as is.
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any held beat immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_grant_q <= '0;
            ptr_q       <= '0;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_grant_q <= out_grant_d;
            ptr_q       <= ptr_d;
`ifdef RR_ARB_MUX_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_grant = out_grant_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed testbench for rr_arb_mux with N=4 channels of 16-bit data.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_rr_arb_mux;

    localparam int N  = 4;
    localparam int NB = 16;

    logic            clk;
    logic            resetn;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*NB-1:0] in_data;
    logic [N-1:0]    in_last;
    logic            out_valid;
    logic            out_ready;
    logic [NB-1:0]   out_data;
    logic            out_last;
    logic [N-1:0]    out_grant;

    int checks;
    int failures;

    rr_arb_mux #(.N(N), .Nbits(NB)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_grant (out_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        resetn    = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset_out_data got=%h exp=0", out_data);
        end
        checks++;
        if (out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_last got=%b exp=0", out_last);
        end
        checks++;
        if (out_grant !== 4'b0000) begin
            failures++;
            $display("FAIL reset_out_grant got=%b exp=0000", out_grant);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=0000", in_ready);
        end
        $display("reset: out_valid=%b out_grant=%b", out_valid, out_grant);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp_g;
        logic [N-1:0] exp_r;
        apply_reset();
        for (int i = 0; i < N; i++) in_data[i*NB +: NB] = NB'(i);
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL rr_first_ready got=%b exp=0001", in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            exp_g = 4'b0001 << (k % 4);
            exp_r = 4'b0001 << ((k + 1) % 4);
            $display("rr beat %0d: out_valid=%b out_data=%0h out_grant=%b", k, out_valid, out_data, out_grant);
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL rr_valid beat=%0d got=%b exp=1", k, out_valid);
            end
            checks++;
            if (out_data !== NB'(k % 4)) begin
                failures++;
                $display("FAIL rr_data beat=%0d got=%0h exp=%0h", k, out_data, k % 4);
            end
            checks++;
            if (out_grant !== exp_g) begin
                failures++;
                $display("FAIL rr_grant beat=%0d got=%b exp=%b", k, out_grant, exp_g);
            end
            checks++;
            if (in_ready !== exp_r) begin
                failures++;
                $display("FAIL rr_ready beat=%0d got=%b exp=%b", k, in_ready, exp_r);
            end
        end
        in_valid = '0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        in_valid              = 4'b0100;
        in_data[2*NB +: NB]   = 16'h00A5;
        out_ready             = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_ready_empty got=%b exp=0100", in_ready);
        end
        step();
        in_data[2*NB +: NB] = 16'h005A;
        for (int k = 0; k < 3; k++) begin
            #1;
            $display("bp stall %0d: out_valid=%b out_data=%0h in_ready=%b", k, out_valid, out_data, in_ready);
            checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h00A5) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got=%b/%0h exp=1/a5", k, out_valid, out_data);
            end
            checks++;
            if (in_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_stall_ready cyc=%0d got=%b exp=0000", k, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_release_ready got=%b exp=0100", in_ready);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h005A || out_grant !== 4'b0100) begin
            failures++;
            $display("FAIL bp_second_beat got=%b/%0h/%b exp=1/5a/0100", out_valid, out_data, out_grant);
        end
        in_valid = '0;
        step();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h005A) begin
            failures++;
            $display("FAIL bp_drain got=%b/%0h exp=0/5a", out_valid, out_data);
        end
    endtask

    task automatic test_wrap_skip();
        apply_reset();
        for (int i = 0; i < N; i++) in_data[i*NB +: NB] = NB'(16'h10 + i);
        out_ready = 1'b1;
        in_valid  = 4'b1000;
        step();
        checks++;
        if (out_grant !== 4'b1000) begin
            failures++;
            $display("FAIL wrap_grant3 got=%b exp=1000", out_grant);
        end
        in_valid = 4'b0101;
        step();
        $display("wrap: out_grant=%b out_data=%0h", out_grant, out_data);
        checks++;
        if (out_grant !== 4'b0001 || out_data !== 16'h0010) begin
            failures++;
            $display("FAIL wrap_grant0 got=%b/%0h exp=0001/10", out_grant, out_data);
        end
        step();
        $display("skip: out_grant=%b out_data=%0h", out_grant, out_data);
        checks++;
        if (out_grant !== 4'b0100 || out_data !== 16'h0012) begin
            failures++;
            $display("FAIL skip_grant2 got=%b/%0h exp=0100/12", out_grant, out_data);
        end
        in_valid = '0;
    endtask

    task automatic test_packet_lock();
        logic [N-1:0] vec_valid [8];
        logic         vec_last1 [8];
        logic         exp_v     [8];
        logic [N-1:0] exp_g     [8];
        vec_valid = '{4'b0010, 4'b0001, 4'b0001, 4'b0011, 4'b0001, 4'b0001, 4'b0011, 4'b0001};
        vec_last1 = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef RR_ARB_MUX_LOCK_EN
        exp_v = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_g = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
`else
        exp_v = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_g = '{4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
`endif
        apply_reset();
        in_data[0*NB +: NB] = 16'h00C0;
        in_data[1*NB +: NB] = 16'h00C1;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_valid   = vec_valid[k];
            in_last    = {2'b00, vec_last1[k], 1'b1};
            step();
            $display("lock edge %0d: out_valid=%b out_grant=%b out_last=%b", k, out_valid, out_grant, out_last);
            checks++;
            if (out_valid !== exp_v[k] || out_grant !== exp_g[k]) begin
                failures++;
                $display("FAIL lock_seq edge=%0d got=%b/%b exp=%b/%b", k, out_valid, out_grant, exp_v[k], exp_g[k]);
            end
        end
        in_valid = '0;
        in_last  = '0;
    endtask

    task automatic test_async_reset();
        apply_reset();
        in_data[1*NB +: NB] = 16'h0077;
        in_last   = 4'b0010;
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        step();
        in_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0077 || out_last !== 1'b1) begin
            failures++;
            $display("FAIL areset_preload got=%b/%0h/%b exp=1/77/1", out_valid, out_data, out_last);
        end
        #2;
        resetn = 1'b0;
        #1;
        $display("areset mid-cycle: out_valid=%b out_grant=%b out_data=%0h", out_valid, out_grant, out_data);
        checks++;
        if (out_valid !== 1'b0 || out_grant !== 4'b0000 || out_data !== '0) begin
            failures++;
            $display("FAIL areset_clear got=%b/%b/%0h exp=0/0000/0", out_valid, out_grant, out_data);
        end
        step();
        resetn = 1'b1;
        for (int i = 0; i < N; i++) in_data[i*NB +: NB] = NB'(16'h20 + i);
        in_last   = '0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin
            failures++;
            $display("FAIL areset_first_ready got=%b exp=0001", in_ready);
        end
        step();
        checks++;
        if (out_grant !== 4'b0001 || out_data !== 16'h0020) begin
            failures++;
            $display("FAIL areset_first_grant got=%b/%0h exp=0001/20", out_grant, out_data);
        end
        in_valid = '0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        resetn    = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap_skip();
        test_packet_lock();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
